// File: rtl/riscv_pkg.sv
// Shared RV32M execute-unit types: decoder op codes, mul/div FSM states and
// the iteration count of the multi-cycle datapath.
package riscv_pkg;

    localparam int XLEN    = 32;
    localparam int MD_ITER = XLEN;

    typedef enum logic [3:0] {
        MD_MUL    = 4'd0,
        MD_MULH   = 4'd1,
        MD_MULHSU = 4'd2,
        MD_MULHU  = 4'd3,
        MD_DIV    = 4'd4,
        MD_DIVU   = 4'd5,
        MD_REM    = 4'd6,
        MD_REMU   = 4'd7,
        MD_NONE   = 4'hF
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } md_state_e;

endpackage

// File: rtl/md_divider.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, trial-subtract the divisor, keep or restore, shift in a quotient bit.
module md_divider #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_in,
    input  logic [XLEN-1:0] quo_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN:0]   rem_out,
    output logic [XLEN-1:0] quo_out
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] diff;

    always_comb begin
        shifted = {rem_in, quo_in[XLEN-1]};
        diff    = shifted - {2'b00, divisor};
        // Top bit of the trial difference set means shifted < divisor: restore.
        if (diff[XLEN+1]) begin
            rem_out = shifted[XLEN:0];
            quo_out = {quo_in[XLEN-2:0], 1'b0};
        end else begin
            rem_out = diff[XLEN:0];
            quo_out = {quo_in[XLEN-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle RV32M unit: 32-step shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up and a fast path for div-by-zero/overflow.
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [3:0]      mul_div_op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic [XLEN-1:0] result,
    output logic            done,
    output logic            busy,
    output logic            stall
);

    import riscv_pkg::*;

    // Handshake: start is a one-cycle request, taken (accept) only in IDLE with
    // op[3]=0 and no flush; otherwise it is dropped. done pulses for exactly one
    // cycle with result valid; stall covers the accept cycle and every busy cycle.

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

    md_state_e         state, state_nxt;
    logic [CNT_W-1:0]  counter;
    md_op_e            op_q;
    logic [XLEN-1:0]   mcand_q;
    logic [XLEN-1:0]   divisor_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN:0]     rem_q;
    logic [2*XLEN-1:0] prod_q;
    logic              neg_q;
    logic              neg_rem_q;

    md_op_e            op_in;
    logic              accept;
    logic              is_div_in;
    logic              a_signed, b_signed;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              div_zero, div_ovf, fast;
    logic [XLEN-1:0]   fast_result;

    logic [XLEN:0]     add_sum;
    logic [2*XLEN-1:0] prod_nxt;
    logic [XLEN:0]     div_rem_nxt;
    logic [XLEN-1:0]   div_quo_nxt;

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN-1:0]   fix_result;

    // Accept-time operand decode and fast-path detection.
    always_comb begin
        op_in     = md_op_e'(mul_div_op);
        accept    = start && (state == IDLE) && !mul_div_op[3] && !flush;
        is_div_in = mul_div_op[2];
        a_signed  = 1'b0;
        b_signed  = 1'b0;
        case (op_in)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            MD_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
        a_neg    = a_signed && rs1_data[XLEN-1];
        b_neg    = b_signed && rs2_data[XLEN-1];
        a_mag    = a_neg ? -rs1_data : rs1_data;
        b_mag    = b_neg ? -rs2_data : rs2_data;
        div_zero = is_div_in && (rs2_data == '0);
        div_ovf  = ((op_in == MD_DIV) || (op_in == MD_REM)) &&
                   (rs1_data == INT_MIN) && (rs2_data == '1);
        fast     = div_zero || div_ovf;
        // op[1] separates remainder (REM/REMU) from quotient (DIV/DIVU).
        if (div_zero) begin
            fast_result = mul_div_op[1] ? rs1_data : '1;
        end else begin
            fast_result = mul_div_op[1] ? '0 : INT_MIN;
        end
    end

    // Shift-add multiply step: conditionally add the multiplicand into the
    // upper half, then shift the whole product right by one.
    always_comb begin
        add_sum  = prod_q[0] ? ({1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q})
                             : {1'b0, prod_q[2*XLEN-1:XLEN]};
        prod_nxt = {add_sum, prod_q[XLEN-1:1]};
    end

    md_divider #(.XLEN(XLEN)) u_divider (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (divisor_q),
        .rem_out (div_rem_nxt),
        .quo_out (div_quo_nxt)
    );

    // Sign correction and result selection, consumed in the FIX state.
    always_comb begin
        prod_fix = neg_q ? -prod_q : prod_q;
        quo_fix  = neg_q ? -quo_q : quo_q;
        rem_fix  = neg_rem_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
        case (op_q)
            MD_MUL:                        fix_result = prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU:  fix_result = prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:               fix_result = quo_fix;
            default:                       fix_result = rem_fix;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = fast ? DONE : CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (counter == LAST_ITER) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = flush ? IDLE : DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter   <= '0;
            op_q      <= MD_MUL;
            mcand_q   <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            rem_q     <= '0;
            prod_q    <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            result    <= '0;
        end else if (accept) begin
            counter   <= '0;
            op_q      <= op_in;
            mcand_q   <= a_mag;
            divisor_q <= b_mag;
            quo_q     <= a_mag;
            rem_q     <= '0;
            prod_q    <= {{XLEN{1'b0}}, b_mag};
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (fast) begin
                result <= fast_result;
            end
        end else if (state == CALC) begin
            counter <= counter + 1'b1;
            if (op_q[2]) begin
                rem_q <= div_rem_nxt;
                quo_q <= div_quo_nxt;
            end else begin
                prod_q <= prod_nxt;
            end
        end else if ((state == FIX) && !flush) begin
            result <= fix_result;
        end
    end

    assign busy  = (state == CALC) || (state == FIX);
    assign stall = busy || accept;
    assign done  = (state == DONE);

endmodule
